// File: rtl/seg_adder_pkg.sv
// Shared types and constants for the segmented adder controller.
package seg_adder_pkg;

  localparam int unsigned DefWidth   = 32;
  localparam int unsigned DefSegment = 8;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCorr = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned calc_nseg(input int unsigned width,
                                            input int unsigned segment);
    return width / segment;
  endfunction

endpackage

// File: rtl/seg_adder_unit.sv
// Single segment adder: {cout_o, sum_o} = a_i + b_i + cin_i.
module seg_adder_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  logic [WIDTH:0] w_total;

  assign w_total = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};
  assign sum_o   = w_total[WIDTH-1:0];
  assign cout_o  = w_total[WIDTH];

endmodule

// File: rtl/seg_adder_seq_ctrl.sv
// Sequencing controller around NSEG segment adders; exact mode ripples dropped carries
// through correction cycles. Optional err_o output under SEG_ADDER_APPROX_ERR_EN.
module seg_adder_seq_ctrl
  import seg_adder_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned SEGMENT = DefSegment
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] add1_i,
  input  logic [WIDTH-1:0] add2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH:0]   result_o,
  output logic             busy_o
`ifdef SEG_ADDER_APPROX_ERR_EN
  ,
  output logic             err_o
`endif
);

  // NSEG must be at least 2 so the pending-carry vector is non-empty.
  localparam int unsigned NSEG = calc_nseg(WIDTH, SEGMENT);

  state_e                       r_state;
  state_e                       w_state_d;
  logic [NSEG-1:0][SEGMENT-1:0] r_sum;
  logic [NSEG-2:0]              r_p;
  logic                         r_cout;
  logic                         r_mode;

  logic [NSEG-1:0][SEGMENT-1:0] w_a;
  logic [NSEG-1:0][SEGMENT-1:0] w_b;
  logic [NSEG-1:0][SEGMENT-1:0] w_s;
  logic [NSEG-1:0]              w_cin;
  logic [NSEG-1:0]              w_co;
  logic                         w_accept;
  logic                         w_corr;
  logic                         w_p_clear;

  assign w_accept  = (r_state == StIdle) && in_valid_i;
  assign w_corr    = (r_state == StCorr);
  assign w_p_clear = (w_co[NSEG-2:0] == '0);

  // Adders see the operands while idle and the registered sums plus pending carries in CORR.
  for (genvar j = 0; j < NSEG; j++) begin : g_seg
    if (j == 0) begin : g_cin0
      assign w_cin[j] = 1'b0;
    end else begin : g_cinj
      assign w_cin[j] = w_corr ? r_p[j-1] : 1'b0;
    end

    assign w_a[j] = w_corr ? r_sum[j] : add1_i[j*SEGMENT +: SEGMENT];
    assign w_b[j] = w_corr ? '0       : add2_i[j*SEGMENT +: SEGMENT];

    seg_adder_unit #(
      .WIDTH (SEGMENT)
    ) u_unit (
      .a_i    (w_a[j]),
      .b_i    (w_b[j]),
      .cin_i  (w_cin[j]),
      .sum_o  (w_s[j]),
      .cout_o (w_co[j])
    );
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (in_valid_i) begin
          if (!mode_i || w_p_clear) w_state_d = StDone;
          else                      w_state_d = StCorr;
        end
      end
      StCorr: begin
        if (!r_mode || w_p_clear) w_state_d = StDone;
      end
      StDone: begin
        if (out_ready_i) w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= StIdle;
      r_sum   <= '0;
      r_p     <= '0;
      r_cout  <= 1'b0;
      r_mode  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_sum  <= w_s;
        r_p    <= w_co[NSEG-2:0];
        r_cout <= w_co[NSEG-1];
        r_mode <= mode_i;
      end else if (w_corr) begin
        // Segment 0 recomputes its own sum with zero addend, so it stays unchanged.
        r_sum  <= w_s;
        r_p    <= w_co[NSEG-2:0];
        r_cout <= r_cout | w_co[NSEG-1];
      end
    end
  end

`ifdef SEG_ADDER_APPROX_ERR_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_accept) begin
      r_err <= !mode_i && !w_p_clear;
    end
  end

  assign err_o = r_err;
`endif

  assign in_ready_o  = (r_state == StIdle);
  assign out_valid_o = (r_state == StDone);
  assign busy_o      = (r_state != StIdle);
  assign result_o    = {r_cout, r_sum};

endmodule

// File: tb/tb_seg_adder_seq_ctrl.sv
// Directed self-checking bench for seg_adder_seq_ctrl (default 32-bit, 8-bit segments).
module tb_seg_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        mode;
  logic [31:0] a1;
  logic [31:0] a2;
  logic        out_valid;
  logic        out_ready;
  logic [32:0] result;
  logic        busy;
`ifdef SEG_ADDER_APPROX_ERR_EN
  logic        err;
`endif

  int tests = 0;
  int fails = 0;
  int cyc;
  logic [32:0] held;

  always #5 clk = ~clk;

  seg_adder_seq_ctrl #(
    .WIDTH   (32),
    .SEGMENT (8)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .mode_i      (mode),
    .add1_i      (a1),
    .add2_i      (a2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .result_o    (result),
    .busy_o      (busy)
`ifdef SEG_ADDER_APPROX_ERR_EN
    ,
    .err_o       (err)
`endif
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one operand pair, then waits (bounded) for out_valid; cycles counts edges from accept.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic m,
                         output int cycles);
    a1       = a;
    a2       = b;
    mode     = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cycles   = 1;
    while (!out_valid && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mode      = 1'b0;
    a1        = '0;
    a2        = '0;
    #12;
    check("rst_result", 64'(result), 64'h0);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_busy", 64'(busy), 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
`ifdef SEG_ADDER_APPROX_ERR_EN
    check("rst_err", 64'(err), 64'h0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: approximate mode drops the segment-0 carry
    run_txn(32'h0000_00FF, 32'h0000_0001, 1'b0, cyc);
    check("t1_result", 64'(result), 64'h0_0000_0000);
    check("t1_latency", 64'(cyc), 64'd1);
`ifdef SEG_ADDER_APPROX_ERR_EN
    check("t1_err", 64'(err), 64'h1);
`endif
    tick();
    check("t1_back_idle", 64'(in_ready), 64'h1);

    // 2: same operands, exact mode needs one correction
    run_txn(32'h0000_00FF, 32'h0000_0001, 1'b1, cyc);
    check("t2_result", 64'(result), 64'h0_0000_0100);
    check("t2_latency", 64'(cyc), 64'd2);
`ifdef SEG_ADDER_APPROX_ERR_EN
    check("t2_err", 64'(err), 64'h0);
`endif
    tick();

    // 3: full ripple, worst case three corrections
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, cyc);
    check("t3_result", 64'(result), 64'h1_0000_0000);
    check("t3_latency", 64'(cyc), 64'd4);
    tick();

    // 4: every segment carries at once, cout set at accept
    run_txn(32'h8080_8080, 32'h8080_8080, 1'b1, cyc);
    check("t4_result", 64'(result), 64'h1_0101_0100);
    check("t4_latency", 64'(cyc), 64'd2);
    tick();

    // 5: backpressure with a competing in_valid
    out_ready = 1'b0;
    run_txn(32'h1234_5678, 32'h1111_1111, 1'b0, cyc);
    check("t5_result", 64'(result), 64'h0_2345_6789);
    held     = result;
    a1       = 32'hFFFF_FFFF;
    a2       = 32'hFFFF_FFFF;
    mode     = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t5_hold_result", 64'(result), 64'(held));
      check("t5_hold_valid", 64'(out_valid), 64'h1);
      check("t5_hold_ready", 64'(in_ready), 64'h0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("t5_idle_ready", 64'(in_ready), 64'h1);
    check("t5_idle_valid", 64'(out_valid), 64'h0);
    check("t5_idle_result", 64'(result), 64'h0_2345_6789);

    // 6: reset mid-correction, then a fresh transaction
    a1       = 32'hFFFF_FFFF;
    a2       = 32'h0000_0001;
    mode     = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_in_corr", 64'(busy), 64'h1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 64'(out_valid), 64'h0);
    check("t6_rst_result", 64'(result), 64'h0);
    check("t6_rst_busy", 64'(busy), 64'h0);
    check("t6_rst_ready", 64'(in_ready), 64'h1);
    #3;
    rst_n = 1'b1;
    tick();
    run_txn(32'h0000_FFFF, 32'h0000_0001, 1'b1, cyc);
    check("t6_after_result", 64'(result), 64'h0_0001_0000);
    check("t6_after_latency", 64'(cyc), 64'd3);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
